// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synch_fifo block: SRAM word/address widths,
// depth, count width and the almost-full threshold.
package sync_fifo_pkg;

   localparam int DW       = 32;
   localparam int AW       = 4;
   localparam int DEPTH    = 1 << AW;
   localparam int CW       = AW + 1;
   localparam int AF_LEVEL = 12;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Write/read pointers, occupancy count and status flag decode for the FIFO.
// Flags are decoded straight from the registered count.
module sync_fifo_ptr
   import sync_fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   output logic          push_ok,
   output logic          pop_ok,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full
);

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign almost_full = (count >= CW'(AF_LEVEL));

   // A push while full is dropped even if a pop frees a slot this cycle.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Push/pop FIFO controller driving a 16x32 dual-port SRAM with registered ports.
// Define SYNC_FIFO_CTRL_ERR_EN to build the sticky overflow/underflow flags.
module sync_fifo_ctrl
   import sync_fifo_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic [CW-1:0] count,
   output logic          overflow,
   output logic          underflow,
   output logic          sram_wren,
   output logic [AW-1:0] sram_wrptr,
   output logic [DW-1:0] sram_wrdata,
   output logic          sram_rden,
   output logic [AW-1:0] sram_rdptr,
   input  logic [DW-1:0] sram_rddata
);

   logic          push_ok;
   logic          pop_ok;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          v1;

   sync_fifo_ptr u_ptr (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .pop         (pop),
      .push_ok     (push_ok),
      .pop_ok      (pop_ok),
      .wr_ptr      (wr_ptr),
      .rd_ptr      (rd_ptr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full)
   );

   assign dout = sram_rddata;

   // Address/data hold when idle; only the enables return to 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sram_wren   <= 1'b0;
         sram_wrptr  <= '0;
         sram_wrdata <= '0;
         sram_rden   <= 1'b0;
         sram_rdptr  <= '0;
      end else begin
         sram_wren <= push_ok;
         sram_rden <= pop_ok;
         if (push_ok) begin
            sram_wrptr  <= wr_ptr;
            sram_wrdata <= din;
         end
         if (pop_ok)
            sram_rdptr <= rd_ptr;
      end
   end

   // v1 tracks the SRAM read cycle; dout_valid lines up with the registered rddata.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1         <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         v1         <= pop_ok;
         dout_valid <= v1;
      end
   end

`ifdef SYNC_FIFO_CTRL_ERR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push && full)
            overflow <= 1'b1;
         if (pop && empty)
            underflow <= 1'b1;
      end
   end
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl with a behavioural SRAM, a reference model and a
// read-data scoreboard; honours SYNC_FIFO_CTRL_ERR_EN for the error flags.
module tb_sync_fifo_ctrl;
   import sync_fifo_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic [DW-1:0] din = '0;
   logic [DW-1:0] dout;
   logic          dout_valid, full, empty, almost_full, overflow, underflow;
   logic [CW-1:0] count;
   logic          sram_wren, sram_rden;
   logic [AW-1:0] sram_wrptr, sram_rdptr;
   logic [DW-1:0] sram_wrdata, sram_rddata;
   logic [DW-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   sync_fifo_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (push),
      .din         (din),
      .pop         (pop),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .count       (count),
      .overflow    (overflow),
      .underflow   (underflow),
      .sram_wren   (sram_wren),
      .sram_wrptr  (sram_wrptr),
      .sram_wrdata (sram_wrdata),
      .sram_rden   (sram_rden),
      .sram_rdptr  (sram_rdptr),
      .sram_rddata (sram_rddata)
   );

   always @(posedge clk) begin
      if (sram_wren)
         mem[sram_wrptr] <= sram_wrdata;
      if (sram_rden)
         sram_rddata <= mem[sram_rdptr];
   end

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   typedef struct {
      logic          push;
      logic          pop;
      logic [DW-1:0] din;
      int            cnt;
      logic          full;
      logic          empty;
   } vec_t;

   exp_t          expq[$];
   logic [DW-1:0] mq[$];
   vec_t          tbl[9];

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            mcount = 0;
   logic [AW-1:0] mwr = '0, mrd = '0, exp_wrptr = '0, exp_rdptr = '0;
   logic [DW-1:0] exp_wrdata = '0;
   logic          mwren = 1'b0, mrden = 1'b0, movf = 1'b0, mudf = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      mcount = 0;
      mq.delete();
      expq.delete();
      mwr = '0; mrd = '0;
      exp_wrptr = '0; exp_rdptr = '0; exp_wrdata = '0;
      mwren = 1'b0; mrden = 1'b0; movf = 1'b0; mudf = 1'b0;
   endtask

   task automatic check_all();
      chk("count", count, mcount);
      chk("full", full, mcount == DEPTH);
      chk("empty", empty, mcount == 0);
      chk("almost_full", almost_full, mcount >= AF_LEVEL);
      chk("sram_wren", sram_wren, mwren);
      chk("sram_wrptr", sram_wrptr, exp_wrptr);
      chk("sram_wrdata", sram_wrdata, exp_wrdata);
      chk("sram_rden", sram_rden, mrden);
      chk("sram_rdptr", sram_rdptr, exp_rdptr);
      chk("overflow", overflow, movf);
      chk("underflow", underflow, mudf);
   endtask

   // Drive one cycle of requests, advance the model at the edge, then check.
   task automatic step(input logic p, input logic q, input logic [DW-1:0] d);
      bit   pa, qa;
      exp_t e;
      push = p; pop = q; din = d;
      @(posedge clk);
      cyc++;
      pa = p && (mcount < DEPTH);
      qa = q && (mcount > 0);
`ifdef SYNC_FIFO_CTRL_ERR_EN
      if (p && mcount == DEPTH) movf = 1'b1;
      if (q && mcount == 0) mudf = 1'b1;
`endif
      if (qa) begin
         e.data = mq.pop_front();
         e.cyc  = cyc;
         expq.push_back(e);
         exp_rdptr = mrd;
         mrd++;
      end
      if (pa) begin
         mq.push_back(d);
         exp_wrptr  = mwr;
         exp_wrdata = d;
         mwr++;
      end
      mwren = pa;
      mrden = qa;
      mcount = mcount + int'(pa) - int'(qa);
      #1;
      push = 1'b0; pop = 1'b0;
      check_all();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("rst_dout_valid", dout_valid, 1'b0);
      @(posedge clk); cyc++;
      @(posedge clk); cyc++;
      #1;
      rst_n = 1'b1;
   endtask

   // Read scoreboard: a popped word must appear exactly one edge after its pop edge.
   always @(negedge clk) begin
      bit want;
      want = (expq.size() > 0) && (expq[0].cyc + 1 == cyc);
      chk("dout_valid", dout_valid, want);
      if (want) begin
         chk("dout", dout, expq[0].data);
         void'(expq.pop_front());
      end
   end

   initial begin
      tbl[0] = '{1'b1, 1'b0, 32'hA1, 1, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 32'hA2, 2, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b1, 32'hA3, 2, 1'b0, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 32'h0,  1, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b1};
      tbl[5] = '{1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 32'hA4, 1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b1};

      #2;
      do_reset();

      for (int i = 0; i < 9; i++) begin
         step(tbl[i].push, tbl[i].pop, tbl[i].din);
         chk("tbl_count", count, tbl[i].cnt);
         chk("tbl_full", full, tbl[i].full);
         chk("tbl_empty", empty, tbl[i].empty);
      end
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Fill, overflow attempt, drain, underflow attempt.
      do_reset();
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b0, 32'h10 + 32'(i));
      chk("fill_full", full, 1'b1);
      chk("fill_count", count, 16);
      step(1'b1, 1'b0, 32'hAA);
`ifdef SYNC_FIFO_CTRL_ERR_EN
      chk("overflow_set", overflow, 1'b1);
`else
      chk("overflow_off", overflow, 1'b0);
`endif
      for (int i = 0; i < 16; i++)
         step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chk("drain_empty", empty, 1'b1);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
`ifdef SYNC_FIFO_CTRL_ERR_EN
      chk("underflow_set", underflow, 1'b1);
`else
      chk("underflow_off", underflow, 1'b0);
`endif

      // Steady state at 3 entries with pointer wrap.
      do_reset();
      for (int i = 0; i < 3; i++)
         step(1'b1, 1'b0, 32'h100 + 32'(i));
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 32'h200 + 32'(i));
         chk("pair_count", count, 3);
      end
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Single word, pop on the cycle after the push.
      do_reset();
      step(1'b1, 1'b0, 32'h55);
      step(1'b0, 1'b1, '0);
      chk("lat_valid_early", dout_valid, 1'b0);
      step(1'b0, 1'b0, '0);
      chk("lat_valid", dout_valid, 1'b1);
      chk("lat_dout", dout, 32'h55);
      step(1'b0, 1'b0, '0);

      // Reset while a read is still in the pipeline.
      step(1'b1, 1'b0, 32'h77);
      step(1'b0, 1'b1, '0);
      #2;
      do_reset();
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_rden", sram_rden, 1'b0);
      chk("mid_rst_rdptr", sram_rdptr, 0);
      chk("mid_rst_wrptr", sram_wrptr, 0);
      chk("mid_rst_wrdata", sram_wrdata, 0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Reset while dout_valid is high drops it immediately.
      step(1'b1, 1'b0, 32'h66);
      step(1'b0, 1'b1, '0);
      step(1'b0, 1'b0, '0);
      chk("pre_rst_valid", dout_valid, 1'b1);
      void'(expq.pop_front());
      rst_n = 1'b0;
      #1;
      chk("valid_drop", dout_valid, 1'b0);
      do_reset();
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
